// File: rtl/game_move_sequencer_pkg.sv
// Shared constants, mode encoding and direction code helpers for the move sequencer.
package game_move_sequencer_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'b00,
        MODE_RECORD = 2'b01,
        MODE_REPLAY = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // One-hot direction to 2-bit storage code; only called with a non-zero legal move.
    function automatic logic [1:0] dir_encode(input logic [3:0] d);
        logic [1:0] c;
        case (d)
            DIR_UP:    c = 2'b00;
            DIR_DOWN:  c = 2'b01;
            DIR_LEFT:  c = 2'b10;
            DIR_RIGHT: c = 2'b11;
            default:   c = 2'b00;
        endcase
        return c;
    endfunction

    // 2-bit storage code back to one-hot direction.
    function automatic logic [3:0] dir_decode(input logic [1:0] c);
        logic [3:0] d;
        case (c)
            2'b00:   d = DIR_UP;
            2'b01:   d = DIR_DOWN;
            2'b10:   d = DIR_LEFT;
            default: d = DIR_RIGHT;
        endcase
        return d;
    endfunction

    // Legal raw codes: a single hot bit, or no direction at all.
    function automatic logic dir_legal(input logic [3:0] d);
        return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) ||
               (d == DIR_RIGHT) || (d == DIR_NONE);
    endfunction

endpackage

// File: rtl/game_move_sequencer_if.sv
// Direction/mode bundle between the button inputs, the sequencer and the game.
interface game_move_sequencer_if #(
    parameter int AW = 4
);
    logic [3:0]  dir_in;
    logic [1:0]  mode;
    logic [3:0]  dir_out;
    logic [AW:0] rec_count;
    logic [AW:0] play_idx;
    logic        rec_full;
    logic        play_done;
    logic        illegal;

    // Driver of buttons/switches; observes the sequencer outputs.
    modport master (
        output dir_in, mode,
        input  dir_out, rec_count, play_idx, rec_full, play_done, illegal
    );

    // The sequencer itself.
    modport slave (
        input  dir_in, mode,
        output dir_out, rec_count, play_idx, rec_full, play_done, illegal
    );
endinterface

// File: rtl/game_move_sequencer_ram.sv
// Move history storage: DEPTH x 2-bit codes, synchronous write, asynchronous read, no reset.
module game_move_sequencer_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [1:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [1:0]    rdata_o
);

    logic [1:0] mem_q [DEPTH];

    // Store one encoded move per enabled step.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/game_move_sequencer.sv
// Sanitises button directions, records legal moves and replays them one per step.
module game_move_sequencer
    import game_move_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                    clk_btn,
    input  logic                    rst_btn,
    game_move_sequencer_if.slave    bus
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    mode_e       mode_q, mode_d;
    logic [3:0]  dir_out_q, dir_out_d;
    logic [AW:0] rec_count_q, rec_count_d;
    logic [AW:0] play_idx_q, play_idx_d;
    logic        play_done_q, play_done_d;
    logic        illegal_q, illegal_d;

    logic          legal;
    logic [3:0]    san_dir;
    logic          entry;
    logic [AW:0]   rec_base;
    logic [AW:0]   play_base;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [1:0]    ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [1:0]    ram_rdata;

    game_move_sequencer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_hist (
        .clk_i   (clk_btn),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // State register: mode_q is the previous sampled mode, used to detect entry.
    always_ff @(posedge clk_btn or posedge rst_btn) begin
        if (rst_btn) begin
            mode_q      <= MODE_LIVE;
            dir_out_q   <= DIR_NONE;
            rec_count_q <= '0;
            play_idx_q  <= '0;
            play_done_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            dir_out_q   <= dir_out_d;
            rec_count_q <= rec_count_d;
            play_idx_q  <= play_idx_d;
            play_done_q <= play_done_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state: sanitise input, then apply the per-mode action for this step.
    // Entry steps substitute zero for the pointer so clear and first access share one edge.
    always_comb begin
        mode_d      = mode_e'(bus.mode);
        legal       = dir_legal(bus.dir_in);
        san_dir     = legal ? bus.dir_in : DIR_NONE;
        entry       = (mode_d != mode_q);
        dir_out_d   = DIR_NONE;
        rec_count_d = rec_count_q;
        play_idx_d  = play_idx_q;
        play_done_d = 1'b0;
        illegal_d   = ~legal;
        rec_base    = '0;
        play_base   = '0;
        ram_we      = 1'b0;
        ram_waddr   = rec_count_q[AW-1:0];
        ram_wdata   = dir_encode(san_dir);
        ram_raddr   = play_idx_q[AW-1:0];

        case (mode_d)
            MODE_LIVE: begin
                dir_out_d = san_dir;
            end
            MODE_RECORD: begin
                rec_base  = entry ? '0 : rec_count_q;
                dir_out_d = san_dir;
                if ((san_dir != DIR_NONE) && (rec_base < DEPTH_C)) begin
                    ram_we      = 1'b1;
                    ram_waddr   = rec_base[AW-1:0];
                    rec_count_d = rec_base + 1'b1;
                end else begin
                    rec_count_d = rec_base;
                end
            end
            MODE_REPLAY: begin
                play_base = entry ? '0 : play_idx_q;
                ram_raddr = play_base[AW-1:0];
                if (play_base < rec_count_q) begin
                    dir_out_d   = dir_decode(ram_rdata);
                    play_idx_d  = play_base + 1'b1;
                    play_done_d = entry ? 1'b0 : play_done_q;
                end else begin
                    dir_out_d   = DIR_NONE;
                    play_idx_d  = play_base;
                    play_done_d = 1'b1;
                end
            end
            MODE_HOLD: begin
                play_done_d = entry ? 1'b0 : play_done_q;
            end
            default: begin
                dir_out_d = DIR_NONE;
            end
        endcase
    end

    assign bus.dir_out   = dir_out_q;
    assign bus.rec_count = rec_count_q;
    assign bus.play_idx  = play_idx_q;
    assign bus.rec_full  = (rec_count_q == DEPTH_C);
    assign bus.play_done = play_done_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_game_move_sequencer.sv
// Directed self-checking bench for game_move_sequencer.
module tb_game_move_sequencer;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    game_move_sequencer_if #(.AW(4)) bus ();

    game_move_sequencer #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk_btn (clk),
        .rst_btn (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] dir_tab [4];
    initial begin
        dir_tab[0] = 4'b1000;
        dir_tab[1] = 4'b0100;
        dir_tab[2] = 4'b0010;
        dir_tab[3] = 4'b0001;
    end

    task automatic step(input logic [3:0] d, input logic [1:0] m);
        @(negedge clk);
        bus.dir_in = d;
        bus.mode   = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.dir_in = 4'b0000;
        bus.mode   = 2'b00;
        #3;
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL reset_dir_out got=%b exp=0000", bus.dir_out); end
        tests_run++; if (bus.rec_count !== 5'd0) begin tests_failed++; $display("FAIL reset_rec_count got=%0d exp=0", bus.rec_count); end
        tests_run++; if (bus.play_idx !== 5'd0) begin tests_failed++; $display("FAIL reset_play_idx got=%0d exp=0", bus.play_idx); end
        tests_run++; if ({bus.rec_full, bus.play_done, bus.illegal} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got=%b exp=000", {bus.rec_full, bus.play_done, bus.illegal}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_live;
        step(4'b0100, 2'b00);
        tests_run++; if (bus.dir_out !== 4'b0100) begin tests_failed++; $display("FAIL live_down got=%b exp=0100", bus.dir_out); end
        step(4'b0000, 2'b00);
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL live_none got=%b exp=0000", bus.dir_out); end
    endtask

    task automatic test_illegal;
        step(4'b1100, 2'b00);
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL illegal_dir got=%b exp=0000", bus.dir_out); end
        tests_run++; if (bus.illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal_set got=%b exp=1", bus.illegal); end
        step(4'b0010, 2'b00);
        tests_run++; if (bus.dir_out !== 4'b0010) begin tests_failed++; $display("FAIL illegal_next_dir got=%b exp=0010", bus.dir_out); end
        tests_run++; if (bus.illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_clear got=%b exp=0", bus.illegal); end
        step(4'b0011, 2'b11);
        tests_run++; if (bus.illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal_hold got=%b exp=1", bus.illegal); end
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL hold_dir got=%b exp=0000", bus.dir_out); end
    endtask

    task automatic test_record_replay;
        logic [3:0] rec_in  [4];
        logic [4:0] rec_cnt [4];
        logic [3:0] rp_out  [5];
        logic [4:0] rp_idx  [5];
        logic       rp_done [5];
        rec_in[0] = 4'b1000; rec_cnt[0] = 5'd1;
        rec_in[1] = 4'b0000; rec_cnt[1] = 5'd1;
        rec_in[2] = 4'b0001; rec_cnt[2] = 5'd2;
        rec_in[3] = 4'b0010; rec_cnt[3] = 5'd3;
        rp_out[0] = 4'b1000; rp_idx[0] = 5'd1; rp_done[0] = 1'b0;
        rp_out[1] = 4'b0001; rp_idx[1] = 5'd2; rp_done[1] = 1'b0;
        rp_out[2] = 4'b0010; rp_idx[2] = 5'd3; rp_done[2] = 1'b0;
        rp_out[3] = 4'b0000; rp_idx[3] = 5'd3; rp_done[3] = 1'b1;
        rp_out[4] = 4'b0000; rp_idx[4] = 5'd3; rp_done[4] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(rec_in[i], 2'b01);
            tests_run++; if (bus.dir_out !== rec_in[i]) begin tests_failed++; $display("FAIL rec_dir[%0d] got=%b exp=%b", i, bus.dir_out, rec_in[i]); end
            tests_run++; if (bus.rec_count !== rec_cnt[i]) begin tests_failed++; $display("FAIL rec_count[%0d] got=%0d exp=%0d", i, bus.rec_count, rec_cnt[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 2'b10);
            tests_run++; if (bus.dir_out !== rp_out[i]) begin tests_failed++; $display("FAIL rp_dir[%0d] got=%b exp=%b", i, bus.dir_out, rp_out[i]); end
            tests_run++; if (bus.play_idx !== rp_idx[i]) begin tests_failed++; $display("FAIL rp_idx[%0d] got=%0d exp=%0d", i, bus.play_idx, rp_idx[i]); end
            tests_run++; if (bus.play_done !== rp_done[i]) begin tests_failed++; $display("FAIL rp_done[%0d] got=%b exp=%b", i, bus.play_done, rp_done[i]); end
        end
        step(4'b0001, 2'b00);
        tests_run++; if (bus.play_done !== 1'b0) begin tests_failed++; $display("FAIL rp_exit_done got=%b exp=0", bus.play_done); end
        tests_run++; if (bus.rec_count !== 5'd3) begin tests_failed++; $display("FAIL rp_exit_count got=%0d exp=3", bus.rec_count); end
        tests_run++; if (bus.dir_out !== 4'b0001) begin tests_failed++; $display("FAIL rp_exit_live got=%b exp=0001", bus.dir_out); end
    endtask

    task automatic test_hold;
        step(4'b0100, 2'b11);
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL hold2_dir got=%b exp=0000", bus.dir_out); end
        tests_run++; if (bus.rec_count !== 5'd3) begin tests_failed++; $display("FAIL hold2_count got=%0d exp=3", bus.rec_count); end
        tests_run++; if (bus.play_idx !== 5'd3) begin tests_failed++; $display("FAIL hold2_idx got=%0d exp=3", bus.play_idx); end
        tests_run++; if (bus.illegal !== 1'b0) begin tests_failed++; $display("FAIL hold2_illegal got=%b exp=0", bus.illegal); end
    endtask

    task automatic test_full;
        logic [4:0] exp_cnt;
        logic       exp_full;
        for (int i = 0; i < 18; i++) begin
            step(dir_tab[i % 4], 2'b01);
            exp_cnt  = (i < 16) ? 5'(i + 1) : 5'd16;
            exp_full = (i >= 15);
            tests_run++; if (bus.rec_count !== exp_cnt) begin tests_failed++; $display("FAIL full_count[%0d] got=%0d exp=%0d", i, bus.rec_count, exp_cnt); end
            tests_run++; if (bus.rec_full !== exp_full) begin tests_failed++; $display("FAIL full_flag[%0d] got=%b exp=%b", i, bus.rec_full, exp_full); end
            tests_run++; if (bus.dir_out !== dir_tab[i % 4]) begin tests_failed++; $display("FAIL full_dir[%0d] got=%b exp=%b", i, bus.dir_out, dir_tab[i % 4]); end
        end
        for (int i = 0; i < 16; i++) begin
            step(4'b0000, 2'b10);
            tests_run++; if (bus.dir_out !== dir_tab[i % 4]) begin tests_failed++; $display("FAIL full_rp_dir[%0d] got=%b exp=%b", i, bus.dir_out, dir_tab[i % 4]); end
            tests_run++; if (bus.play_done !== 1'b0) begin tests_failed++; $display("FAIL full_rp_done[%0d] got=%b exp=0", i, bus.play_done); end
        end
        step(4'b0000, 2'b10);
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL full_rp_end_dir got=%b exp=0000", bus.dir_out); end
        tests_run++; if (bus.play_done !== 1'b1) begin tests_failed++; $display("FAIL full_rp_end_done got=%b exp=1", bus.play_done); end
        tests_run++; if (bus.play_idx !== 5'd16) begin tests_failed++; $display("FAIL full_rp_end_idx got=%0d exp=16", bus.play_idx); end
    endtask

    task automatic test_empty_replay;
        step(4'b0000, 2'b01);
        tests_run++; if (bus.rec_count !== 5'd0) begin tests_failed++; $display("FAIL empty_count got=%0d exp=0", bus.rec_count); end
        tests_run++; if (bus.rec_full !== 1'b0) begin tests_failed++; $display("FAIL empty_full got=%b exp=0", bus.rec_full); end
        step(4'b0001, 2'b10);
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL empty_rp_dir got=%b exp=0000", bus.dir_out); end
        tests_run++; if (bus.play_done !== 1'b1) begin tests_failed++; $display("FAIL empty_rp_done got=%b exp=1", bus.play_done); end
        tests_run++; if (bus.play_idx !== 5'd0) begin tests_failed++; $display("FAIL empty_rp_idx got=%0d exp=0", bus.play_idx); end
    endtask

    task automatic test_reset_mid_replay;
        step(4'b1000, 2'b01);
        step(4'b0100, 2'b01);
        step(4'b0001, 2'b01);
        step(4'b0000, 2'b10);
        step(4'b0000, 2'b10);
        tests_run++; if (bus.play_idx !== 5'd2) begin tests_failed++; $display("FAIL mid_idx got=%0d exp=2", bus.play_idx); end
        tests_run++; if (bus.dir_out !== 4'b0100) begin tests_failed++; $display("FAIL mid_dir got=%b exp=0100", bus.dir_out); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++; if (bus.dir_out !== 4'b0000) begin tests_failed++; $display("FAIL arst_dir got=%b exp=0000", bus.dir_out); end
        tests_run++; if (bus.rec_count !== 5'd0) begin tests_failed++; $display("FAIL arst_count got=%0d exp=0", bus.rec_count); end
        tests_run++; if (bus.play_idx !== 5'd0) begin tests_failed++; $display("FAIL arst_idx got=%0d exp=0", bus.play_idx); end
        tests_run++; if (bus.play_done !== 1'b0) begin tests_failed++; $display("FAIL arst_done got=%b exp=0", bus.play_done); end
        #1;
        rst = 1'b0;
        step(4'b0001, 2'b00);
        tests_run++; if (bus.rec_count !== 5'd0) begin tests_failed++; $display("FAIL post_rst_count got=%0d exp=0", bus.rec_count); end
        tests_run++; if (bus.dir_out !== 4'b0001) begin tests_failed++; $display("FAIL post_rst_live got=%b exp=0001", bus.dir_out); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_live();
        test_illegal();
        test_record_replay();
        test_hold();
        test_full();
        test_empty_replay();
        test_reset_mid_replay();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
